// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter plus N-to-1 data mux sharing one output channel.
//   An IDLE cycle picks the next requester (searching upward from rr_ptr with
//   wrap-around), then the grant is held in GRANT until a beat with last
//   transfers. Data/valid/last of the granted requester pass straight through.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_last     per-requester handshake, [N_INPUTS-1:0]
//   in_data              packed requester data, requester i at [i*DW +: DW]
//   in_ready             per-requester ready, only the granted bit can be 1
//   out_valid/last/data  shared output channel
//   out_ready            downstream ready
//   sel_o                registered grant index
//   busy                 1 while in GRANT

// Per-requester slice: gates the requester's signals onto the AND-OR mux and
// returns ready only when this requester holds the grant.
module rr_mux_lane #(
  parameter int DW = 8
) (
  input  logic          gnt,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          valid_m,
  output logic          last_m,
  output logic [DW-1:0] data_m
);
  assign in_ready = gnt & out_ready;
  assign valid_m  = gnt & in_valid;
  assign last_m   = gnt & in_last;
  assign data_m   = {DW{gnt}} & in_data;
endmodule

module rr_mux_arbiter #(
  parameter  int N_INPUTS = 4,
  parameter  int DW       = 8,
  localparam int SW       = $clog2(N_INPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_INPUTS-1:0]    in_valid,
  input  logic [N_INPUTS-1:0]    in_last,
  input  logic [N_INPUTS*DW-1:0] in_data,
  output logic [N_INPUTS-1:0]    in_ready,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [DW-1:0]          out_data,
  input  logic                   out_ready,
  output logic [SW-1:0]          sel_o,
  output logic                   busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Search index needs one extra bit: rr_ptr + offset reaches 2*N-2 before wrap.
  localparam logic [SW:0]   N_L      = (SW+1)'(N_INPUTS);
  localparam logic [SW-1:0] LAST_IDX = SW'(N_INPUTS-1);

  logic [0:0]                    state;
  logic [SW-1:0]                 sel_q;
  logic [SW-1:0]                 rr_ptr;
  logic [SW-1:0]                 winner;
  logic                          any_req;
  logic [SW:0]                   idx;
  logic [N_INPUTS-1:0]           gnt_vec;
  logic [N_INPUTS-1:0]           vld_m;
  logic [N_INPUTS-1:0]           lst_m;
  logic [N_INPUTS-1:0][DW-1:0]   dat_m;
  logic                          pkt_end;

  // Rotating priority search, modulo N_INPUTS (not 2^SW) so a non-power-of-2
  // requester count never yields an out-of-range select.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      idx = {1'b0, rr_ptr} + (SW+1)'(k);
      if (idx >= N_L) idx = idx - N_L;
      if (!any_req && in_valid[idx[SW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[SW-1:0];
      end
    end
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
    assign gnt_vec[i] = (state == S_GRANT) && (sel_q == SW'(i));
    rr_mux_lane #(.DW(DW)) u_lane (
      .gnt      (gnt_vec[i]),
      .in_valid (in_valid[i]),
      .in_last  (in_last[i]),
      .in_data  (in_data[i*DW +: DW]),
      .out_ready(out_ready),
      .in_ready (in_ready[i]),
      .valid_m  (vld_m[i]),
      .last_m   (lst_m[i]),
      .data_m   (dat_m[i])
    );
  end

  // At most one lane is enabled, so OR-reduction acts as the mux.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_INPUTS; i++) out_data = out_data | dat_m[i];
  end

  assign out_valid = |vld_m;
  assign out_last  = |lst_m;
  assign sel_o     = sel_q;
  assign busy      = (state == S_GRANT);

  // out_valid/out_last are already gated to the granted requester.
  assign pkt_end = out_valid && out_ready && out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sel_q  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel_q  <= winner;
            rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Bubbles (in_valid low) keep the grant; only a last transfer ends it.
          if (pkt_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  iv, il, ir;
  logic [31:0] id;
  logic        ov, ol, ordy, busy;
  logic [7:0]  od;
  logic [1:0]  sel;

  logic [2:0]  iv3, il3, ir3;
  logic [23:0] id3;
  logic        ov3, ol3, ordy3, busy3;
  logic [7:0]  od3;
  logic [1:0]  sel3;

  int tests_run = 0;
  int tests_failed = 0;

  rr_mux_arbiter #(.N_INPUTS(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_last(il), .in_data(id),
    .in_ready(ir), .out_valid(ov), .out_last(ol), .out_data(od),
    .out_ready(ordy), .sel_o(sel), .busy(busy)
  );

  rr_mux_arbiter #(.N_INPUTS(3), .DW(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_last(il3), .in_data(id3),
    .in_ready(ir3), .out_valid(ov3), .out_last(ol3), .out_data(od3),
    .out_ready(ordy3), .sel_o(sel3), .busy(busy3)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    iv = '0; il = '0; id = '0; ordy = 0;
    iv3 = '0; il3 = '0; id3 = '0; ordy3 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    iv = '0; il = '0; id = '0; ordy = 0;
    iv3 = '0; il3 = '0; id3 = '0; ordy3 = 0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || sel !== 2'd0 || ov !== 1'b0 || ol !== 1'b0 || od !== 8'h00 || ir !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b sel=%0d ov=%b ol=%b od=%h ir=%b, want 0", busy, sel, ov, ol, od, ir);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // grant requester 2, then reset mid-packet
    iv = 4'b0100; id = 32'h00_77_00_00; ordy = 1;
    cyc();
    tests_run++;
    if (busy !== 1'b1 || sel !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_pre_grant: busy=%b sel=%0d, want busy=1 sel=2", busy, sel);
    end
    #2 rst = 1;
    #1;
    tests_run++;
    if (sel !== 2'd0 || busy !== 1'b0 || ov !== 1'b0 || ir !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_async: sel=%0d busy=%b ov=%b ir=%b, want all 0", sel, busy, ov, ir);
    end
    iv = 4'b0010;
    #1 rst = 0;
    cyc();
    tests_run++;
    if (sel !== 2'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_regrant: sel=%0d busy=%b, want sel=1 busy=1", sel, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    iv = 4'b0100; il = 4'b0100; id = 32'h00_A5_00_00; ordy = 1;
    #1;
    tests_run++;
    if (ov !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: ov=%b busy=%b, want 0 0", ov, busy);
    end
    cyc();
    tests_run++;
    if (ov !== 1'b1 || od !== 8'hA5 || ir !== 4'b0100 || sel !== 2'd2 || ol !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: ov=%b od=%h ir=%b sel=%0d ol=%b, want 1 a5 0100 2 1", ov, od, ir, sel, ol);
    end
    cyc();
    tests_run++;
    if (busy !== 1'b0 || ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: busy=%b ov=%b, want 0 0", busy, ov);
    end
    iv = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    iv = 4'b1111; il = 4'b1111; id = 32'h44_33_22_11; ordy = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      tests_run++;
      if (busy !== 1'b1 || sel !== 2'(k % 4) || od !== 8'(8'h11 * ((k % 4) + 1))) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: busy=%b sel=%0d od=%h, want busy=1 sel=%0d", k, busy, sel, od, k % 4);
      end
      cyc();
      tests_run++;
      if (busy !== 1'b0 || ov !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_gap%0d: busy=%b ov=%b, want 0 0", k, busy, ov);
      end
    end
    iv = '0;
  endtask

  task automatic test_burst_hold();
    do_reset();
    ordy = 1;
    iv = 4'b0010; il = 4'b0001; id = 32'h00_00_10_EE;
    cyc();
    iv = 4'b0011;
    #1;
    tests_run++;
    if (sel !== 2'd1 || ov !== 1'b1 || od !== 8'h10 || ol !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_b0: sel=%0d ov=%b od=%h ol=%b, want 1 1 10 0", sel, ov, od, ol);
    end
    cyc();
    id[15:8] = 8'h11;
    #1;
    tests_run++;
    if (sel !== 2'd1 || od !== 8'h11) begin
      tests_failed++;
      $display("FAIL burst_b1: sel=%0d od=%h, want 1 11", sel, od);
    end
    cyc();
    iv[1] = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (sel !== 2'd1 || busy !== 1'b1 || ov !== 1'b0 || ir !== 4'b0010) begin
        tests_failed++;
        $display("FAIL burst_bubble%0d: sel=%0d busy=%b ov=%b ir=%b, want 1 1 0 0010", k, sel, busy, ov, ir);
      end
      cyc();
    end
    iv[1] = 1; il[1] = 1; id[15:8] = 8'h12;
    #1;
    tests_run++;
    if (sel !== 2'd1 || ov !== 1'b1 || od !== 8'h12 || ol !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_b2: sel=%0d ov=%b od=%h ol=%b, want 1 1 12 1", sel, ov, od, ol);
    end
    cyc();
    iv[1] = 0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_gap: busy=%b ov=%b, want 0 0", busy, ov);
    end
    cyc();
    tests_run++;
    if (busy !== 1'b1 || sel !== 2'd0 || od !== 8'hEE) begin
      tests_failed++;
      $display("FAIL burst_next: busy=%b sel=%0d od=%h, want 1 0 ee", busy, sel, od);
    end
    iv = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    iv = 4'b1000; il = 4'b1000; id = 32'h3C_00_00_00; ordy = 0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (ov !== 1'b1 || od !== 8'h3C || ir !== 4'b0000 || sel !== 2'd3 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: ov=%b od=%h ir=%b sel=%0d busy=%b, want 1 3c 0000 3 1", k, ov, od, ir, sel, busy);
      end
      cyc();
    end
    ordy = 1;
    #1;
    tests_run++;
    if (ir !== 4'b1000 || ov !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: ir=%b ov=%b, want 1000 1", ir, ov);
    end
    cyc();
    iv = '0;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_done: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_wrap3();
    do_reset();
    iv3 = 3'b111; il3 = 3'b111; id3 = 24'h33_22_11; ordy3 = 1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      tests_run++;
      if (busy3 !== 1'b1 || sel3 !== 2'(k % 3) || od3 !== 8'(8'h11 * ((k % 3) + 1))) begin
        tests_failed++;
        $display("FAIL wrap3_grant%0d: busy=%b sel=%0d od=%h, want 1 %0d", k, busy3, sel3, od3, k % 3);
      end
      cyc();
      tests_run++;
      if (sel3 === 2'd3 || busy3 !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrap3_gap%0d: sel=%0d busy=%b, want sel<3 busy=0", k, sel3, busy3);
      end
    end
    iv3 = '0;
  endtask

  // Reference model: packet-level view of the arbiter (who owns the channel,
  // where the next search starts).
  task automatic test_random();
    int m_busy, m_g, m_ptr, found, p;
    logic [3:0] exp_ir;
    logic [7:0] exp_d;
    logic       exp_v, exp_l;
    do_reset();
    m_busy = 0; m_g = 0; m_ptr = 0;
    for (int c = 0; c < 600; c++) begin
      iv   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      il   = 4'($urandom_range(0, 15));
      id   = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      exp_v  = m_busy ? iv[m_g] : 1'b0;
      exp_l  = m_busy ? il[m_g] : 1'b0;
      exp_d  = m_busy ? id[m_g*8 +: 8] : 8'h00;
      exp_ir = m_busy ? (4'(ordy) << m_g) : 4'h0;
      tests_run++;
      if (busy !== (m_busy != 0) || sel !== 2'(m_g) || ov !== exp_v || ol !== exp_l || od !== exp_d || ir !== exp_ir) begin
        tests_failed++;
        $display("FAIL rand_c%0d: busy=%b sel=%0d ov=%b ol=%b od=%h ir=%b, want %0d %0d %b %b %h %b",
                 c, busy, sel, ov, ol, od, ir, m_busy, m_g, exp_v, exp_l, exp_d, exp_ir);
      end
      @(posedge clk);
      if (m_busy == 0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          p = (m_ptr + k) % 4;
          if (found == 0 && iv[p]) begin found = 1; m_g = p; end
        end
        if (found != 0) begin
          m_ptr  = (m_g + 1) % 4;
          m_busy = 1;
        end
      end else if (iv[m_g] && ordy && il[m_g]) begin
        m_busy = 0;
      end
      #1;
    end
    iv = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_hold();
    test_backpressure();
    test_wrap3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
